// File: rtl/mmeta_dispatch_if.sv
// Handshake bundle between the control machine, the dispatcher and its two consumers.
// The slave modport is the dispatcher's view of the bundle. The master modport is the environment's view.
interface mmeta_dispatch_if #(
    parameter type meta_glb_t     = logic,
    parameter int  MaxOutstanding = 4
);
    localparam int CntW = $clog2(MaxOutstanding + 1);

    logic            meta_valid_i;
    logic            meta_ready_o;
    meta_glb_t       meta_i;
    logic            seq_valid_o;
    logic            seq_ready_i;
    meta_glb_t       seq_o;
    logic            shf_valid_o;
    logic            shf_ready_i;
    meta_glb_t       shf_o;
    logic            seq_done_i;
    logic            shf_done_i;
    logic [CntW-1:0] seq_cnt_o;
    logic [CntW-1:0] shf_cnt_o;
    logic            idle_o;
    logic            err_o;

    modport slave (
        input  meta_valid_i, meta_i, seq_ready_i, shf_ready_i, seq_done_i, shf_done_i,
        output meta_ready_o, seq_valid_o, seq_o, shf_valid_o, shf_o,
               seq_cnt_o, shf_cnt_o, idle_o, err_o
    );

    modport master (
        output meta_valid_i, meta_i, seq_ready_i, shf_ready_i, seq_done_i, shf_done_i,
        input  meta_ready_o, seq_valid_o, seq_o, shf_valid_o, shf_o,
               seq_cnt_o, shf_cnt_o, idle_o, err_o
    );
endinterface

// File: rtl/mmeta_dispatch_ctrl.sv
// Broadcasts each meta-info packet to the sequential and shuffle consumers and tracks in-flight work per consumer.
// Optional macro MMETA_DISPATCH_ERR_EN enables the sticky done-underflow flag on err_o.
module mmeta_dispatch_ctrl #(
    parameter type meta_glb_t     = logic,
    parameter int  MaxOutstanding = 4,
    localparam int CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    mmeta_dispatch_if.slave bus
);
    typedef enum logic {IDLE, DISPATCH} state_e;

    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

    state_e          state_q, state_d;
    meta_glb_t       hold_q, hold_d;
    logic            pend_seq_q, pend_seq_d;
    logic            pend_shf_q, pend_shf_d;
    logic [CntW-1:0] seq_cnt_q, seq_cnt_d;
    logic [CntW-1:0] shf_cnt_q, shf_cnt_d;
    logic            meta_ready;
    logic            meta_hs, seq_hs, shf_hs;

    // A done without a matching dispatch saturates at zero instead of wrapping.
    function automatic logic [CntW-1:0] cnt_next(input logic [CntW-1:0] cnt,
                                                 input logic inc, input logic dec);
        if (inc == dec) return cnt;
        if (inc)        return cnt + CntW'(1);
        return (cnt == '0) ? '0 : cnt - CntW'(1);
    endfunction

    assign meta_ready = (state_q == IDLE) && (seq_cnt_q < MaxCnt) && (shf_cnt_q < MaxCnt);
    assign meta_hs    = bus.meta_valid_i && meta_ready;
    assign seq_hs     = pend_seq_q && bus.seq_ready_i;
    assign shf_hs     = pend_shf_q && bus.shf_ready_i;

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        pend_seq_d = pend_seq_q;
        pend_shf_d = pend_shf_q;
        case (state_q)
            IDLE: begin
                if (meta_hs) begin
                    hold_d     = bus.meta_i;
                    pend_seq_d = 1'b1;
                    pend_shf_d = 1'b1;
                    state_d    = DISPATCH;
                end
            end
            DISPATCH: begin
                if (seq_hs) pend_seq_d = 1'b0;
                if (shf_hs) pend_shf_d = 1'b0;
                if (!pend_seq_d && !pend_shf_d) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        seq_cnt_d = cnt_next(seq_cnt_q, seq_hs, bus.seq_done_i);
        shf_cnt_d = cnt_next(shf_cnt_q, shf_hs, bus.shf_done_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            pend_seq_q <= 1'b0;
            pend_shf_q <= 1'b0;
            seq_cnt_q  <= '0;
            shf_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            pend_seq_q <= pend_seq_d;
            pend_shf_q <= pend_shf_d;
            seq_cnt_q  <= seq_cnt_d;
            shf_cnt_q  <= shf_cnt_d;
        end
    end

`ifdef MMETA_DISPATCH_ERR_EN
    logic err_q, err_d;

    function automatic logic cnt_underflow(input logic [CntW-1:0] cnt,
                                           input logic inc, input logic dec);
        return dec && !inc && (cnt == '0);
    endfunction

    always_comb begin
        err_d = err_q
              | cnt_underflow(seq_cnt_q, seq_hs, bus.seq_done_i)
              | cnt_underflow(shf_cnt_q, shf_hs, bus.shf_done_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign bus.err_o = err_q;
`else
    assign bus.err_o = 1'b0;
`endif

    assign bus.meta_ready_o = meta_ready;
    assign bus.seq_valid_o  = pend_seq_q;
    assign bus.shf_valid_o  = pend_shf_q;
    assign bus.seq_o        = hold_q;
    assign bus.shf_o        = hold_q;
    assign bus.seq_cnt_o    = seq_cnt_q;
    assign bus.shf_cnt_o    = shf_cnt_q;
    assign bus.idle_o       = (state_q == IDLE) && (seq_cnt_q == '0) && (shf_cnt_q == '0);
endmodule

// File: tb/tb_mmeta_dispatch_ctrl.sv
// Bench for mmeta_dispatch_ctrl: directed scenarios plus random traffic against a queue-based reference model.
module tb_mmeta_dispatch_ctrl;
    typedef logic [15:0] meta_t;
    localparam int MAX = 4;
`ifdef MMETA_DISPATCH_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    mmeta_dispatch_if #(.meta_glb_t(meta_t), .MaxOutstanding(MAX)) bus ();

    mmeta_dispatch_ctrl #(.meta_glb_t(meta_t), .MaxOutstanding(MAX)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: one delivery queue per consumer and plain integer in-flight counts.
    meta_t m_seq_q[$];
    meta_t m_shf_q[$];
    meta_t m_last;
    int    m_seq_cnt, m_shf_cnt;
    bit    m_err;

    function automatic bit exp_ready();
        return (m_seq_q.size() == 0) && (m_shf_q.size() == 0) && (m_seq_cnt < MAX) && (m_shf_cnt < MAX);
    endfunction

    function automatic bit exp_idle();
        return (m_seq_q.size() == 0) && (m_shf_q.size() == 0) && (m_seq_cnt == 0) && (m_shf_cnt == 0);
    endfunction

    task automatic step(input bit r, input bit mv, input meta_t md, input bit sr, input bit fr,
                        input bit sd, input bit fd);
        bit acc, shs, fhs;
        rst = r;
        bus.meta_valid_i = mv;
        bus.meta_i       = md;
        bus.seq_ready_i  = sr;
        bus.shf_ready_i  = fr;
        bus.seq_done_i   = sd;
        bus.shf_done_i   = fd;
        if (r) begin
            m_seq_q.delete();
            m_shf_q.delete();
            m_last = '0;
            m_seq_cnt = 0;
            m_shf_cnt = 0;
            m_err = 1'b0;
        end else begin
            acc = mv && exp_ready();
            shs = sr && (m_seq_q.size() != 0);
            fhs = fr && (m_shf_q.size() != 0);
            if (shs) void'(m_seq_q.pop_front());
            if (fhs) void'(m_shf_q.pop_front());
            if (acc) begin
                m_seq_q.push_back(md);
                m_shf_q.push_back(md);
                m_last = md;
            end
            m_seq_cnt = m_seq_cnt + int'(shs) - int'(sd);
            if (m_seq_cnt < 0) begin m_seq_cnt = 0; m_err = 1'b1; end
            m_shf_cnt = m_shf_cnt + int'(fhs) - int'(fd);
            if (m_shf_cnt < 0) begin m_shf_cnt = 0; m_err = 1'b1; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic dispatch_full(input meta_t d);
        step(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.meta_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", bus.meta_ready_o); end
        checks++; if (bus.seq_valid_o !== 1'b0 || bus.shf_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b%b exp 00", bus.seq_valid_o, bus.shf_valid_o); end
        checks++; if (bus.seq_o !== 16'h0 || bus.shf_o !== 16'h0) begin errors++; $display("FAIL rst_data got %h/%h exp 0000", bus.seq_o, bus.shf_o); end
        checks++; if (bus.seq_cnt_o !== 3'd0 || bus.shf_cnt_o !== 3'd0) begin errors++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", bus.seq_cnt_o, bus.shf_cnt_o); end
        checks++; if (bus.idle_o !== 1'b1 || bus.err_o !== 1'b0) begin errors++; $display("FAIL rst_idle_err got %b/%b exp 1/0", bus.idle_o, bus.err_o); end
    endtask

    task automatic test_basic();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'hA5A5, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.seq_valid_o !== 1'b1 || bus.shf_valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid got %b%b exp 11", bus.seq_valid_o, bus.shf_valid_o); end
        checks++; if (bus.seq_o !== 16'hA5A5 || bus.shf_o !== 16'hA5A5) begin errors++; $display("FAIL basic_data got %h/%h exp a5a5", bus.seq_o, bus.shf_o); end
        checks++; if (bus.idle_o !== 1'b0 || bus.meta_ready_o !== 1'b0) begin errors++; $display("FAIL basic_busy got idle %b ready %b exp 0 0", bus.idle_o, bus.meta_ready_o); end
        step(1'b0, 1'b1, 16'h1111, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.seq_cnt_o !== 3'd1 || bus.shf_cnt_o !== 3'd1) begin errors++; $display("FAIL basic_cnt got %0d/%0d exp 1/1", bus.seq_cnt_o, bus.shf_cnt_o); end
        checks++; if (bus.seq_valid_o !== 1'b0 || bus.shf_valid_o !== 1'b0 || bus.meta_ready_o !== 1'b1) begin errors++; $display("FAIL basic_back_idle got v %b%b ready %b exp 00 1", bus.seq_valid_o, bus.shf_valid_o, bus.meta_ready_o); end
    endtask

    task automatic test_shf_stall();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 16'h2222, 1'b1, 1'b0, 1'b0, 1'b0);
            checks++; if (bus.seq_valid_o !== 1'b0 || bus.shf_valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid cyc %0d got %b%b exp 01", i, bus.seq_valid_o, bus.shf_valid_o); end
            checks++; if (bus.shf_o !== 16'hBEEF || bus.meta_ready_o !== 1'b0) begin errors++; $display("FAIL stall_hold cyc %0d got %h ready %b exp beef 0", i, bus.shf_o, bus.meta_ready_o); end
            checks++; if (bus.seq_cnt_o !== 3'd1 || bus.shf_cnt_o !== 3'd0) begin errors++; $display("FAIL stall_cnt cyc %0d got %0d/%0d exp 1/0", i, bus.seq_cnt_o, bus.shf_cnt_o); end
        end
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.shf_valid_o !== 1'b0 || bus.meta_ready_o !== 1'b1) begin errors++; $display("FAIL stall_release got v %b ready %b exp 0 1", bus.shf_valid_o, bus.meta_ready_o); end
        checks++; if (bus.seq_cnt_o !== 3'd1 || bus.shf_cnt_o !== 3'd1) begin errors++; $display("FAIL stall_final_cnt got %0d/%0d exp 1/1", bus.seq_cnt_o, bus.shf_cnt_o); end
    endtask

    task automatic test_full();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < MAX; i++) dispatch_full(meta_t'(16'h100 + i));
        checks++; if (bus.seq_cnt_o !== 3'd4 || bus.shf_cnt_o !== 3'd4 || bus.meta_ready_o !== 1'b0) begin errors++; $display("FAIL full_cnt got %0d/%0d ready %b exp 4/4 0", bus.seq_cnt_o, bus.shf_cnt_o, bus.meta_ready_o); end
        step(1'b0, 1'b1, 16'hDEAD, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.seq_valid_o !== 1'b0 || bus.seq_o !== 16'h103) begin errors++; $display("FAIL full_blocked got v %b data %h exp 0 0103", bus.seq_valid_o, bus.seq_o); end
        step(1'b0, 1'b1, 16'hDEAD, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++; if (bus.seq_cnt_o !== 3'd3 || bus.shf_cnt_o !== 3'd4 || bus.meta_ready_o !== 1'b0) begin errors++; $display("FAIL full_seq_done got %0d/%0d ready %b exp 3/4 0", bus.seq_cnt_o, bus.shf_cnt_o, bus.meta_ready_o); end
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (bus.shf_cnt_o !== 3'd3 || bus.meta_ready_o !== 1'b1) begin errors++; $display("FAIL full_shf_done got %0d ready %b exp 3 1", bus.shf_cnt_o, bus.meta_ready_o); end
    endtask

    task automatic test_same_cycle();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        dispatch_full(16'h0001);
        dispatch_full(16'h0002);
        step(1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++; if (bus.seq_cnt_o !== 3'd2 || bus.shf_cnt_o !== 3'd3) begin errors++; $display("FAIL same_cycle got %0d/%0d exp 2/3", bus.seq_cnt_o, bus.shf_cnt_o); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL same_cycle_err got %b exp 0", bus.err_o); end
    endtask

    task automatic test_underflow();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (bus.shf_cnt_o !== 3'd0) begin errors++; $display("FAIL underflow_cnt got %0d exp 0", bus.shf_cnt_o); end
        checks++; if (bus.err_o !== ERR_EN) begin errors++; $display("FAIL underflow_err got %b exp %b", bus.err_o, ERR_EN); end
        dispatch_full(16'h0042);
        checks++; if (bus.err_o !== ERR_EN || bus.seq_cnt_o !== 3'd1) begin errors++; $display("FAIL underflow_sticky got err %b cnt %0d exp %b 1", bus.err_o, bus.seq_cnt_o, ERR_EN); end
    endtask

    task automatic test_reset_dispatch();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        dispatch_full(16'h0055);
        step(1'b0, 1'b1, 16'h0077, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.seq_valid_o !== 1'b0 || bus.shf_valid_o !== 1'b0) begin errors++; $display("FAIL rstdisp_valid got %b%b exp 00", bus.seq_valid_o, bus.shf_valid_o); end
        checks++; if (bus.seq_cnt_o !== 3'd0 || bus.shf_cnt_o !== 3'd0 || bus.idle_o !== 1'b1) begin errors++; $display("FAIL rstdisp_cnt got %0d/%0d idle %b exp 0/0 1", bus.seq_cnt_o, bus.shf_cnt_o, bus.idle_o); end
        checks++; if (bus.shf_o !== 16'h0 || bus.meta_ready_o !== 1'b1) begin errors++; $display("FAIL rstdisp_data got %h ready %b exp 0000 1", bus.shf_o, bus.meta_ready_o); end
    endtask

    task automatic test_random();
        bit mv, sr, fr, sd, fd;
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 600; i++) begin
            mv = ($urandom_range(0, 3) != 0);
            sr = ($urandom_range(0, 2) != 0);
            fr = ($urandom_range(0, 2) != 0);
            sd = (m_seq_cnt > 0) && ($urandom_range(0, 3) == 0);
            fd = (m_shf_cnt > 0) && ($urandom_range(0, 3) == 0);
            step(1'b0, mv, meta_t'($urandom), sr, fr, sd, fd);
            checks++; if (bus.meta_ready_o !== exp_ready()) begin errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", i, bus.meta_ready_o, exp_ready()); end
            checks++; if (bus.seq_valid_o !== (m_seq_q.size() != 0) || bus.shf_valid_o !== (m_shf_q.size() != 0)) begin errors++; $display("FAIL rnd_valid cyc %0d got %b%b exp %b%b", i, bus.seq_valid_o, bus.shf_valid_o, m_seq_q.size() != 0, m_shf_q.size() != 0); end
            checks++; if (bus.seq_o !== m_last || bus.shf_o !== m_last) begin errors++; $display("FAIL rnd_data cyc %0d got %h/%h exp %h", i, bus.seq_o, bus.shf_o, m_last); end
            checks++; if (int'(bus.seq_cnt_o) != m_seq_cnt || int'(bus.shf_cnt_o) != m_shf_cnt) begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d/%0d exp %0d/%0d", i, bus.seq_cnt_o, bus.shf_cnt_o, m_seq_cnt, m_shf_cnt); end
            checks++; if (bus.idle_o !== exp_idle() || bus.err_o !== (ERR_EN & m_err)) begin errors++; $display("FAIL rnd_idle_err cyc %0d got %b/%b exp %b/%b", i, bus.idle_o, bus.err_o, exp_idle(), ERR_EN & m_err); end
        end
    endtask

    initial begin
        bus.meta_valid_i = 1'b0;
        bus.meta_i       = '0;
        bus.seq_ready_i  = 1'b0;
        bus.shf_ready_i  = 1'b0;
        bus.seq_done_i   = 1'b0;
        bus.shf_done_i   = 1'b0;
        test_reset();
        test_basic();
        test_shf_stall();
        test_full();
        test_same_cycle();
        test_underflow();
        test_reset_dispatch();
        test_random();
        idle_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mmeta_dispatch_ctrl.md
MMETA_DISPATCH_CTRL -- requirements
Module: mmeta_dispatch_ctrl

Interface
REQ-001 SHALL have parameter meta_glb_t, default logic, the matrix meta-info packet type.
REQ-002 SHALL have parameter MaxOutstanding, default 4, the per-consumer in-flight instruction limit (legal range 1..15).
REQ-003 SHALL have derived localparam CntW = $clog2(MaxOutstanding+1), the outstanding-counter width.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, the reset: synchronous, active-high.
REQ-006 SHALL have ports meta_valid_i (input, 1), meta_ready_o (output, 1) and meta_i (input, meta_glb_t), the meta-info request from the control machine.
REQ-007 SHALL have ports seq_valid_o (output, 1), seq_ready_i (input, 1) and seq_o (output, meta_glb_t), the dispatch to the sequential modules.
REQ-008 SHALL have ports shf_valid_o (output, 1), shf_ready_i (input, 1) and shf_o (output, meta_glb_t), the dispatch to the shuffle modules.
REQ-009 SHALL have ports seq_done_i and shf_done_i, input, 1 each, a single-cycle pulse per instruction retired by that consumer.
REQ-010 SHALL have port seq_cnt_o, output, CntW, the sequential-side outstanding count.
REQ-011 SHALL have port shf_cnt_o, output, CntW, the shuffle-side outstanding count.
REQ-012 SHALL have port idle_o, output, 1, high when the FSM is IDLE and both counts are 0.
REQ-013 SHALL have port err_o, output, 1, the sticky done-underflow flag.

Function
REQ-014 SHALL implement a two-state FSM: IDLE and DISPATCH.
REQ-015 In IDLE, meta_ready_o SHALL equal (seq_cnt_o < MaxOutstanding) && (shf_cnt_o < MaxOutstanding); it SHALL be 0 in DISPATCH.
REQ-016 On an input handshake in IDLE, SHALL register meta_i into a holding register, set pend_seq=1 and pend_shf=1, and move to DISPATCH.
REQ-017 seq_o and shf_o SHALL both drive the holding register; seq_valid_o=pend_seq and shf_valid_o=pend_shf, with no combinational path from any input to any valid output.
REQ-018 Each consumer handshake SHALL clear only its own pend flag, independently of the other consumer.
REQ-019 Once a pend flag is set, its valid SHALL stay asserted with stable data until its handshake completes.
REQ-020 When both pend flags are 0 at the end of a cycle (including both handshakes in the same cycle), the FSM SHALL return to IDLE on the next edge.
REQ-021 Minimum dispatch latency SHALL be 1 cycle (input handshake to valid), and maximum throughput SHALL be one packet per 2 cycles.
REQ-022 seq_cnt_o SHALL increment on a seq handshake and decrement on seq_done_i; shf_cnt_o SHALL behave the same way with shf handshake and shf_done_i.
REQ-023 A simultaneous increment and decrement on the same counter SHALL leave that counter unchanged.
REQ-024 A done pulse while its counter is 0 SHALL leave the counter at 0 and set err_o.
REQ-025 A counter at MaxOutstanding SHALL block new input acceptance in IDLE; an in-progress DISPATCH SHALL still complete, because acceptance was already gated.

Reset
REQ-026 With rst_i high at a rising edge, the block SHALL enter IDLE, clear the pend flags, both counters and err_o, and set the holding register to '0.
REQ-027 After reset, outputs SHALL read: meta_ready_o=1, seq_valid_o=0, shf_valid_o=0, seq_o/shf_o='0, counts 0, idle_o=1, err_o=0.
REQ-028 A reset during DISPATCH SHALL drop the pending packet without completing its handshakes.

Configuration
REQ-029 Macro MMETA_DISPATCH_ERR_EN SHALL, when defined, include the err_o sticky-flag logic of REQ-024 and REQ-026, cleared only by rst_i.
REQ-030 When MMETA_DISPATCH_ERR_EN is undefined, err_o SHALL be tied to 0 and underflow SHALL still saturate the counters at 0.

Verification
REQ-031 Scenario: reset, then meta_i=A with both readies high -> seq_valid_o and shf_valid_o high with data A in cycle 1; idle_o=0; both counts=1 in cycle 2; FSM back in IDLE.
REQ-032 Scenario: shf_ready_i low for 3 cycles while seq_ready_i=1 -> seq handshakes once; shf_valid_o holds A for 3 cycles; meta_ready_o stays 0 until shf accepts.
REQ-033 Scenario: MaxOutstanding=4, 4 packets dispatched with no done pulses -> meta_ready_o=0 with counts=4; one seq_done_i pulse -> seq_cnt_o=3, but meta_ready_o stays 0 while shf_cnt_o=4.
REQ-034 Scenario: seq handshake and seq_done_i in the same cycle with seq_cnt_o=2 -> seq_cnt_o stays 2.
REQ-035 Scenario: shf_done_i pulse with shf_cnt_o=0 -> shf_cnt_o=0; err_o=1 with MMETA_DISPATCH_ERR_EN defined, 0 without it.
REQ-036 Scenario: rst_i asserted in DISPATCH with shf pending -> next cycle all valids 0, counts 0, idle_o=1.
